acc_cpu_core: RTL
=================

Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU core; next generation of the 8-bit fetch/decode/execute datapath.
- Owns the fetch/decode/execute sequencer, program counter, instruction register, accumulator, flag register and ALU.
- Adds generic width, immediate/direct addressing, conditional branches, shifts, halt and an illegal-mode trap.
- Talks to an external combinational instruction ROM and a synchronous data RAM. Display and clock-divider logic stay outside.

Parameters:
- DATA_W, 8: accumulator, ALU, operand and RAM data width.
- PC_W, 8: program counter and instruction ROM address width.
- ADDR_W, 8: data RAM address width. Must be ≤ DATA_W; RAM address = operand[ADDR_W-1:0].
- INSTR_W, DATA_W+6: instruction width, derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  while low, the core holds in FETCH and does not advance.
- instr_addr  out  PC_W  ROM address, equals PC.
- instr_data  in  INSTR_W  ROM word, combinationally valid for instr_addr.
- ram_addr  out  ADDR_W  data RAM address.
- ram_wdata  out  DATA_W  data RAM write data, equals ACC.
- ram_we  out  1  one-cycle write strobe.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr is presented.
- acc_out  out  DATA_W  accumulator.
- flags_out  out  4  {C,Z,N,V}.
- state_out  out  3  one-hot {EXEC,DECODE,FETCH}; all-zero in MEMRD/HALT.
- halted  out  1  core stopped by HLT or by an illegal mode.
- err  out  1  sticky illegal-mode trap.

Behaviour:

Reset:
- When rst=1 at a clk edge: PC=0, IR=0, ACC=0, flags=0, state=FETCH, ram_we=0, halted=0, err=0.
- Reset overrides run and aborts any instruction in progress. A pending STA does not write.

Instruction format:
- [INSTR_W-1:DATA_W+2] = opcode (4 bits).
- [DATA_W+1:DATA_W] = mode: 00 immediate, 01 direct (operand = RAM address), 1x illegal.
- [DATA_W-1:0] = operand.

FSM (states FETCH, DECODE, MEMRD, EXEC, HALT):
- FETCH: if run, latch IR<=instr_data and go to DECODE; else stay.
- DECODE: PC<=PC+1 (wraps modulo 2^PC_W).
  - Illegal mode: err<=1, go to HALT.
  - Mode 01 and opcode in {LDA, ADD, SUB, AND, OR, XOR}: drive ram_addr and go to MEMRD.
  - Otherwise go to EXEC.
- MEMRD: B<=ram_rdata; go to EXEC.
- EXEC: perform the operation; go to FETCH, or to HALT for HLT.
- HALT: absorbing; halted=1. Only rst leaves it.

Latency:
- Immediate or non-memory instruction: 3 cycles.
- Direct-operand read: 4 cycles.
- STA: 3 cycles; ram_we=1 for exactly the EXEC cycle with ram_addr=operand and ram_wdata=ACC. STA ignores mode 00 vs 01 and always writes direct.

Opcodes:
- 0 NOP.
- 1 LDA: ACC=B.
- 2 STA.
- 3 ADD, 4 SUB.
- 5 AND, 6 OR, 7 XOR.
- 8 NOT: ACC=~ACC.
- 9 SHL, A SHR: logical shifts by 1.
- B JMP.
- C JZ, D JC, E JN.
- F HLT.
- B is the immediate operand or the RAM data.
- Jumps load PC<=operand[PC_W-1:0] in EXEC, overriding the DECODE increment. Conditions are sampled from the current flags. Jump not taken = NOP.

Flags (updated only in EXEC):
- ADD: C = carry-out; V = signed overflow.
- SUB: result = ACC+~B+1; C=1 when no borrow (ACC ≥ B unsigned); V = signed overflow.
- AND/OR/XOR/NOT: C=0, V=0.
- SHL: C=ACC[DATA_W-1]. SHR: C=ACC[0]. V=0 for both.
- Z and N are updated from the result for all ALU ops and LDA.
- LDA keeps C and V.
- NOP/STA/jumps/HLT leave all flags unchanged.

Arithmetic:
- All arithmetic is DATA_W wide, with the carry taken from a DATA_W+1 sum.
- PC wrap from 2^PC_W-1 to 0 is silent.

Test Plan:
1. Reset then LDA #0x7F, ADD #0x01 -> ACC=0x80, flags C=0 Z=0 N=1 V=1. LDA completes in exactly 3 cycles.
2. RAM[0x10]=0x05; LDA #0x03, SUB 0x10 (direct) -> ACC=0xFE, C=0 N=1 Z=0 V=0. SUB completes in 4 cycles.
3. LDA #0xA5, STA 0x20 -> ram_we high for one cycle with ram_addr=0x20 and ram_wdata=0xA5. A subsequent LDA 0x20 returns 0xA5.
4. LDA #0x00, JZ 0x40 -> next instr_addr=0x40. Then LDA #0x01, JZ 0x00 -> falls through to PC+1.
5. Mode=10 at PC=3 -> err=1, halted=1, PC=4. Later HLT/run toggles have no effect. rst returns all outputs to reset values.
6. run=0 for 5 cycles at FETCH -> PC and state unchanged. rst asserted during the EXEC of STA -> no ram_we pulse; state=FETCH and PC=0 next cycle.

Source files
------------

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: fetch/decode/memrd/exec sequencer, PC, IR, ACC, flags and ALU.
// Instruction ROM is combinational; data RAM is synchronous with one cycle of read latency.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int ADDR_W = 8,
  localparam int INSTR_W = DATA_W + 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_we,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [DATA_W-1:0]  acc_out,
  output logic [3:0]         flags_out,
  output logic [2:0]         state_out,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_NOT, OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JC, OP_JN, OP_HLT
  } opcode_t;

  localparam logic [PC_W-1:0]   PC_ONE  = PC_W'(1);
  localparam logic [DATA_W:0]   SUM_ONE = (DATA_W + 1)'(1);
  localparam int                MSB     = DATA_W - 1;

  state_t              state, state_next;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   b_reg;
  logic [3:0]          flags;
  logic                err_q;

  opcode_t             opcode;
  logic [1:0]          mode;
  logic [DATA_W-1:0]   operand;
  logic                needs_mem;

  assign opcode  = opcode_t'(ir[INSTR_W-1:DATA_W+2]);
  assign mode    = ir[DATA_W+1:DATA_W];
  assign operand = ir[DATA_W-1:0];
  assign needs_mem = (mode == 2'b01) &&
                     (opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_next = state;
    case (state)
      S_FETCH:  if (run) state_next = S_DECODE;
      S_DECODE: begin
        if (mode[1])        state_next = S_HALT;
        else if (needs_mem) state_next = S_MEMRD;
        else                state_next = S_EXEC;
      end
      S_MEMRD:  state_next = S_EXEC;
      S_EXEC:   state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // ALU and branch condition, evaluated from IR, ACC, B and the current flags
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              c_next, v_next;
  logic              acc_we;
  logic              jump_taken;
  logic [3:0]        flags_next;

  always_comb begin
    sum        = '0;
    alu_res    = acc;
    c_next     = flags[3];
    v_next     = flags[0];
    acc_we     = 1'b0;
    jump_taken = 1'b0;
    case (opcode)
      OP_LDA: begin
        alu_res = b_reg;
        acc_we  = 1'b1;
      end
      OP_ADD: begin
        sum     = {1'b0, acc} + {1'b0, b_reg};
        alu_res = sum[DATA_W-1:0];
        c_next  = sum[DATA_W];
        v_next  = (acc[MSB] == b_reg[MSB]) && (alu_res[MSB] != acc[MSB]);
        acc_we  = 1'b1;
      end
      OP_SUB: begin
        sum     = {1'b0, acc} + {1'b0, ~b_reg} + SUM_ONE;
        alu_res = sum[DATA_W-1:0];
        c_next  = sum[DATA_W];
        v_next  = (acc[MSB] != b_reg[MSB]) && (alu_res[MSB] != acc[MSB]);
        acc_we  = 1'b1;
      end
      OP_AND: begin alu_res = acc & b_reg; c_next = 1'b0; v_next = 1'b0; acc_we = 1'b1; end
      OP_OR:  begin alu_res = acc | b_reg; c_next = 1'b0; v_next = 1'b0; acc_we = 1'b1; end
      OP_XOR: begin alu_res = acc ^ b_reg; c_next = 1'b0; v_next = 1'b0; acc_we = 1'b1; end
      OP_NOT: begin alu_res = ~acc;        c_next = 1'b0; v_next = 1'b0; acc_we = 1'b1; end
      OP_SHL: begin
        alu_res = {acc[DATA_W-2:0], 1'b0};
        c_next  = acc[MSB];
        v_next  = 1'b0;
        acc_we  = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, acc[DATA_W-1:1]};
        c_next  = acc[0];
        v_next  = 1'b0;
        acc_we  = 1'b1;
      end
      OP_JMP: jump_taken = 1'b1;
      OP_JZ:  jump_taken = flags[2];
      OP_JC:  jump_taken = flags[3];
      OP_JN:  jump_taken = flags[1];
      default: ;
    endcase
    flags_next = acc_we ? {c_next, (alu_res == '0), alu_res[MSB], v_next} : flags;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      b_reg <= '0;
      flags <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (run) ir <= instr_data;
        S_DECODE: begin
          pc    <= pc + PC_ONE;
          b_reg <= operand;
          if (mode[1]) err_q <= 1'b1;
        end
        S_MEMRD:  b_reg <= ram_rdata;
        S_EXEC: begin
          if (acc_we) acc <= alu_res;
          flags <= flags_next;
          // Jump target assumes PC_W <= DATA_W; it overrides the DECODE increment.
          if (jump_taken) pc <= ir[PC_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // rst gates the strobe so a reset landing on STA's EXEC cycle never reaches the RAM.
  assign ram_we     = (state == S_EXEC) && (opcode == OP_STA) && !rst;
  assign ram_addr   = operand[ADDR_W-1:0];
  assign ram_wdata  = acc;
  assign instr_addr = pc;
  assign acc_out    = acc;
  assign flags_out  = flags;
  assign state_out  = {state == S_EXEC, state == S_DECODE, state == S_FETCH};
  assign halted     = (state == S_HALT);
  assign err        = err_q;

endmodule
